// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath types: default sample width, signed sample type and
// the add/sub select encodings driven by the rotation-direction sign bit.
package cordic_pkg;

  localparam int DATA_W = 8;

  typedef logic signed [DATA_W-1:0] data_t;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/addorsub_mux2_core.sv
// Purpose: combinational 2:1 select between add-path and subtract-path values.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows its inputs every cycle.
module addorsub_mux2_core #(
  parameter int DATA_W = cordic_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic              sel_i,
  output logic [DATA_W-1:0] y_o
);
  import cordic_pkg::*;

  assign y_o = (sel_i == SEL_SUB) ? d1_i : d0_i;

endmodule

// File: rtl/addorsub_mux2_reg.sv
// Purpose: registered add/sub select feeding the next CORDIC stage, with valid flag.
// Latency: 1 cycle from in_valid to out_valid; y_output holds when idle.
// Backpressure: none; accepts a sample every cycle.
module addorsub_mux2_reg #(
  parameter int                 DATA_W    = cordic_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        d0_in,
  input  logic [DATA_W-1:0]        d1_in,
  input  logic                     sel_in,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] y_output,
  output logic                     out_valid
);
  import cordic_pkg::*;

  logic [DATA_W-1:0] sel_y;
  logic [DATA_W-1:0] y_d, y_q;
  logic              vld_d, vld_q;

  addorsub_mux2_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .d0_i  (d0_in),
    .d1_i  (d1_in),
    .sel_i (sel_in),
    .y_o   (sel_y)
  );

  // Idle cycles keep the last result so the next stage can sample it late.
  always_comb begin
    y_d   = y_q;
    vld_d = 1'b0;
    if (in_valid) begin
      y_d   = sel_y;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= RESET_VAL;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign y_output  = $signed(y_q);
  assign out_valid = vld_q;

  a_sel_known : assert property (@(posedge clk) disable iff (rst)
                                 in_valid |-> !$isunknown(sel_in))
    else $error("sel_in unknown while in_valid is high");

endmodule

// File: tb/tb_addorsub_mux2_reg.sv
// Directed bench for addorsub_mux2_reg: reset, select, signed view, streaming,
// hold and reset-mid-stream, all against hand-computed expectations.
module tb_addorsub_mux2_reg;

  localparam int DATA_W = 8;

  logic                     clk;
  logic                     rst;
  logic [DATA_W-1:0]        d0_in;
  logic [DATA_W-1:0]        d1_in;
  logic                     sel_in;
  logic                     in_valid;
  logic signed [DATA_W-1:0] y_output;
  logic                     out_valid;

  int n_checks = 0;
  int n_errors = 0;

  addorsub_mux2_reg #(
    .DATA_W    (DATA_W),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d0_in     (d0_in),
    .d1_in     (d1_in),
    .sel_in    (sel_in),
    .in_valid  (in_valid),
    .y_output  (y_output),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    sel_in   = s;
    d0_in    = a;
    d1_in    = b;
  endtask

  task automatic expect_out(input string tag, input int y, input int v);
    check({tag, "_y"}, int'(y_output), y);
    check({tag, "_vld"}, int'(out_valid), v);
  endtask

  logic [7:0] stream_sel;
  int         stream_exp [4] = '{45, 30, 45, 30};

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'd45, 8'd30);

    // Reset held for two edges with valid traffic present.
    tick; expect_out("rst_c0", 0, 0);
    tick; expect_out("rst_c1", 0, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'd45, 8'd30);
    tick; expect_out("rst_after", 0, 0);

    drive(1'b1, 1'b0, 8'd45, 8'd30);
    tick; expect_out("sel0", 45, 1);
    drive(1'b1, 1'b1, 8'd45, 8'd30);
    tick; expect_out("sel1", 30, 1);

    drive(1'b1, 1'b0, 8'hD3, 8'd30);
    tick; expect_out("neg45", -45, 1);
    drive(1'b1, 1'b1, 8'd45, 8'h80);
    tick; expect_out("neg128", -128, 1);

    stream_sel = 8'b0000_1010;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream_sel[i], 8'd45, 8'd30);
      tick; expect_out($sformatf("stream%0d", i), stream_exp[i], 1);
    end

    drive(1'b0, 1'b0, 8'd99, 8'd77);
    tick; expect_out("hold0", 30, 0);
    tick; expect_out("hold1", 30, 0);

    drive(1'b1, 1'b0, 8'd45, 8'd30);
    tick; expect_out("pre_rst", 45, 1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'd45, 8'd30);
    tick; expect_out("mid_rst", 0, 0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'd12, 8'd30);
    tick; expect_out("post_rst", 12, 1);
    drive(1'b0, 1'b1, 8'd12, 8'd30);
    tick; expect_out("post_idle", 12, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addorsub_mux2_reg.md
Name: addorsub_mux2_reg

Overview:
Registered 2:1 selector for the CORDIC datapath. Chooses between the add-path operand/result (d0_in) and the subtract-path operand/result (d1_in) under control of sel_in, typically the rotation-direction sign bit. The selection is presented one clock later on a signed output with a valid flag. Sits between the per-iteration add/sub units and the next CORDIC stage register.

Parameters:
DATA_W, 8, width of d0_in, d1_in and y_output in bits (two's complement on output)
RESET_VAL, 0, value loaded into y_output on reset

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
d0_in  input  DATA_W  candidate 0 (add path), passed bit-exact
d1_in  input  DATA_W  candidate 1 (subtract path), passed bit-exact
sel_in  input  1  0 selects d0_in, 1 selects d1_in
in_valid  input  1  qualifies d0_in/d1_in/sel_in this cycle
y_output  output  DATA_W  registered selection, declared signed
out_valid  output  1  high the cycle after an accepted in_valid

Behaviour:
- Reset: while rst is high at a rising edge, y_output <= RESET_VAL and out_valid <= 0. rst takes priority over every other input in that cycle.
- Latency: exactly 1 clock. At edge N with in_valid=1: y_output <= (sel_in ? d1_in : d0_in) and out_valid <= 1.
- Edge with in_valid=0: out_valid <= 0 and y_output holds its previous value (no update, no clear).
- No backpressure: a new sample is accepted every cycle, so back-to-back in_valid gives a stream of results at full throughput.
- Data is bit-exact. No arithmetic, sign extension or truncation. Input bit patterns are reinterpreted as signed only on y_output, so 8'hFF reads as -1.
- sel_in is treated as 0/1 only. X on sel_in when in_valid=1 is a protocol violation, flagged by a simulation-only assertion.
- Reset mid-stream: a sample presented in the same cycle as rst is discarded. The first valid output after reset comes 1 cycle after the first in_valid sampled with rst low.
- No combinational path from any input to any output.

Decomposition:
- Shared package cordic_pkg holds DATA_W default (8), typedef data_t = logic signed [DATA_W-1:0], and localparams SEL_ADD=1'b0 and SEL_SUB=1'b1.
- One natural sub-module: addorsub_mux2_core, a purely combinational 2:1 select (d0, d1, sel -> y).
- The top wraps addorsub_mux2_core with the output/valid register, reset logic and assertions.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1, d0=45, d1=30 -> y_output=0 and out_valid=0 throughout, and 1 cycle after rst deasserts.
2. Select 0: d0=45, d1=30, sel=0, in_valid=1 -> next cycle y_output=45, out_valid=1.
3. Select 1: same data, sel=1 -> next cycle y_output=30, out_valid=1.
4. Signed reinterpretation: d0=8'hD3, sel=0 -> y_output=-45; d1=8'h80, sel=1 -> y_output=-128.
5. Hold and streaming: alternate sel 0/1 every cycle with in_valid=1 (45/30) -> outputs 45,30,45,30 each one cycle late. Then drop in_valid -> out_valid=0 and y_output holds the last value.
6. Reset mid-stream: rst high in the cycle with sel=1 -> y_output=0 and out_valid=0 next cycle. The sample is dropped and the next valid sample appears 1 cycle after it.
